// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus launch sequencer feeding a UART transmitter that runs on a
//   divided baud clock. Bytes are pushed from the host side; the head byte is
//   presented on dintx with newd held high until the transmitter's start bit
//   is observed on tx_in, then the frame is retired on the rising edge of
//   donetx_in. Both transmitter-side inputs are synchronized into clk.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   wr_en        write strobe, one byte per cycle
//   wr_data      byte to enqueue
//   full/empty   registered occupancy flags
//   count        bytes stored, including the byte currently being sent
//   overflow     1-cycle pulse when a write is attempted while full
//   newd         launch request to the transmitter
//   dintx        byte presented to the transmitter
//   tx_in        transmitter serial output (asynchronous)
//   donetx_in    transmitter done flag (asynchronous)
//   busy         sequencer not idle
//   byte_sent    1-cycle pulse when a frame completes
//   timeout_err  1-cycle pulse when a launch or a frame takes too long
module uart_tx_fifo #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   newd,
    output logic [7:0]             dintx,
    input  logic                   tx_in,
    input  logic                   donetx_in,
    output logic                   busy,
    output logic                   byte_sent,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // ---- transmitter-side synchronizers ----
    logic tx_meta_q, tx_s_q;
    logic done_meta_q, done_s_q, done_dly_q;
    logic done_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_meta_q   <= 1'b1;
            tx_s_q      <= 1'b1;
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
            done_dly_q  <= 1'b0;
        end else begin
            tx_meta_q   <= tx_in;
            tx_s_q      <= tx_meta_q;
            done_meta_q <= donetx_in;
            done_s_q    <= done_meta_q;
            done_dly_q  <= done_s_q;
        end
    end

    assign done_rise = done_s_q & ~done_dly_q;

    // ---- FIFO storage and occupancy ----
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          wr_accept, pop;

    // The registered full flag gates writes, so a write in the same cycle as
    // a pop from a full FIFO is still rejected.
    assign wr_accept = wr_en & ~full_q;

    always_comb begin
        count_d = count_q;
        if (wr_accept & ~pop) begin
            count_d = count_q + CW'(1);
        end else if (~wr_accept & pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            overflow_q <= wr_en & full_q;
        end
    end

    // ---- launch sequencer ----
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic          expired;
    logic          newd_q, busy_q, byte_sent_q, timeout_err_q;
    logic [7:0]    dintx_q;

    // The timer holds the number of cycles already spent in the state, so
    // the limit is hit on the edge that closes the TIMEOUT-th cycle.
    assign expired = (timer_q >= T_LAST);

    // The head leaves the FIFO only once its frame is over, either completed
    // or abandoned; a launch that was never acknowledged keeps its byte.
    assign pop = (state_q == WAIT_DONE) & (done_rise | expired);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            newd_q        <= 1'b0;
            dintx_q       <= 8'h00;
            busy_q        <= 1'b0;
            byte_sent_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            byte_sent_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Launch only while the line is idle and done is low, so a
                    // stale done level cannot retire the new frame.
                    if (~empty_q & tx_s_q & ~done_s_q) begin
                        dintx_q <= mem_q[rd_ptr_q];
                        newd_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (~tx_s_q) begin
                        newd_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= WAIT_DONE;
                    end else if (expired) begin
                        newd_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= GAP;
                    end else if (timer_q != T_MAX) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        byte_sent_q <= 1'b1;
                        timer_q     <= '0;
                        state_q     <= GAP;
                    end else if (expired) begin
                        timeout_err_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= GAP;
                    end else if (timer_q != T_MAX) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                GAP: begin
                    if (~done_s_q & tx_s_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    newd_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    timer_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign newd        = newd_q;
    assign dintx       = dintx_q;
    assign busy        = busy_q;
    assign byte_sent   = byte_sent_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. The reference model is a queue of
//   the bytes the transmitter is expected to be asked to send, in order; a
//   small transmitter emulator with random latencies answers launch requests.
module tb_uart_tx_fifo;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 4096;
    localparam int CW      = $clog2(DEPTH) + 1;

    localparam int XM_AUTO   = 0;
    localparam int XM_NODONE = 2;
    localparam int XM_MANUAL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full, empty, overflow, newd, busy, byte_sent, timeout_err;
    logic [CW-1:0] count;
    logic [7:0]    dintx;
    logic          tx_in, donetx_in;

    uart_tx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .newd        (newd),
        .dintx       (dintx),
        .tx_in       (tx_in),
        .donetx_in   (donetx_in),
        .busy        (busy),
        .byte_sent   (byte_sent),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] launch_q[$];
    logic [7:0] exp_q[$];
    int         n_sent, n_to, n_ovf;
    logic       newd_prev;
    int         xm_mode, xs, xcnt, frames_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample after the edge, log events, then let the transmitter
    // emulator choose its line levels for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (newd && !newd_prev) launch_q.push_back(dintx);
        newd_prev = newd;
        if (byte_sent)   n_sent++;
        if (timeout_err) n_to++;
        if (overflow)    n_ovf++;
        if (xm_mode != XM_MANUAL) begin
            case (xs)
                0: if (newd && tx_in && !donetx_in) begin
                       xs = 1; xcnt = int'($urandom_range(0, 3));
                   end
                1: if (xcnt == 0) begin
                       tx_in = 1'b0; xs = 2; xcnt = int'($urandom_range(4, 10));
                   end else xcnt--;
                2: if (xcnt == 0) begin
                       tx_in = 1'b1;
                       if (xm_mode == XM_AUTO) begin
                           donetx_in = 1'b1; frames_done++;
                           xs = 3; xcnt = int'($urandom_range(0, 3));
                       end else xs = 0;
                   end else xcnt--;
                3: if (xcnt == 0) begin
                       donetx_in = 1'b0; xs = 0;
                   end else xcnt--;
                default: xs = 0;
            endcase
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit acc);
        wr_en   = 1'b1;
        wr_data = b;
        cyc();
        wr_en   = 1'b0;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic wait_newd(input logic lvl, input string tag);
        int n = 0;
        while (newd !== lvl && n < 40) begin cyc(); n++; end
        chk(tag, 32'(newd), 32'(lvl));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(empty && !busy && xs == 0) && n < 4000) begin cyc(); n++; end
        chk(tag, 32'(empty & ~busy), 1);
    endtask

    task automatic cmp_launch(input string tag);
        chk({tag, "_n"}, 32'(launch_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < launch_q.size()) chk(tag, 32'(launch_q[i]), 32'(exp_q[i]));
        end
        launch_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int base, pend, stall;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        tx_in = 1'b1; donetx_in = 1'b0;
        newd_prev = 1'b0; n_sent = 0; n_to = 0; n_ovf = 0;
        xm_mode = XM_MANUAL; xs = 0; xcnt = 0; frames_done = 0;

        // Reset state
        repeat (3) cyc();
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_newd", 32'(newd), 0);
        chk("rst_dintx", 32'(dintx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sent", 32'(byte_sent), 0);
        chk("rst_to", 32'(timeout_err), 0);
        rst = 1'b0;
        repeat (6) cyc();

        // Single byte, hand-driven transmitter
        wr(8'hA5, 1'b1);
        chk("t1_newd_early", 32'(newd), 0);
        chk("t1_empty", 32'(empty), 0);
        chk("t1_count", 32'(count), 1);
        cyc();
        chk("t1_newd", 32'(newd), 1);
        chk("t1_dintx", 32'(dintx), 32'h A5);
        chk("t1_busy", 32'(busy), 1);
        tx_in = 1'b0;
        cyc(); cyc();
        chk("t1_newd_hold", 32'(newd), 1);
        cyc();
        chk("t1_newd_drop", 32'(newd), 0);
        tx_in = 1'b1; donetx_in = 1'b1;
        n = 0;
        while (!byte_sent && n < 10) begin cyc(); n++; end
        chk("t1_byte_sent", 32'(byte_sent), 1);
        chk("t1_count_after", 32'(count), 0);
        chk("t1_empty_after", 32'(empty), 1);
        cyc();
        chk("t1_sent_pulse", 32'(byte_sent), 0);
        chk("t1_busy_gap", 32'(busy), 1);
        donetx_in = 1'b0;
        n = 0;
        while (busy && n < 10) begin cyc(); n++; end
        chk("t1_busy_fall", 32'(busy), 0);
        cmp_launch("t1_order");

        // Fill to DEPTH, then one extra write that must be dropped
        n_ovf = 0; n_sent = 0;
        for (int i = 0; i < DEPTH; i++) wr(8'(i), 1'b1);
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), DEPTH);
        chk("t2_ovf_pre", 32'(overflow), 0);
        wr(8'hFF, 1'b0);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_count_ovf", 32'(count), DEPTH);
        cyc();
        chk("t2_ovf_pulse", 32'(overflow), 0);
        xm_mode = XM_AUTO;
        drain("t2_drain");
        chk("t2_ovf_cnt", 32'(n_ovf), 1);
        chk("t2_sent_cnt", 32'(n_sent), DEPTH);
        cmp_launch("t2_order");

        // Launch never acknowledged: abort, keep the byte, retry it
        xm_mode = XM_MANUAL; n_to = 0;
        wr(8'h3C, 1'b1);
        cyc();
        chk("t3_newd", 32'(newd), 1);
        n = 0;
        while (!timeout_err && n < TIMEOUT + 500) begin cyc(); n++; end
        chk("t3_to_cycles", 32'(n), TIMEOUT);
        chk("t3_newd_off", 32'(newd), 0);
        chk("t3_count", 32'(count), 1);
        exp_q.push_back(8'h3C);
        wait_newd(1'b1, "t3_reissue");
        chk("t3_dintx", 32'(dintx), 32'h3C);

        // Start bit seen but done never comes: abort and drop the byte
        wr(8'h5A, 1'b1);
        chk("t4_count", 32'(count), 2);
        xm_mode = XM_NODONE;
        wait_newd(1'b0, "t4_start");
        n = 0;
        while (!timeout_err && n < TIMEOUT + 500) begin cyc(); n++; end
        chk("t4_to_cycles", 32'(n), TIMEOUT);
        chk("t4_count", 32'(count), 1);
        chk("t4_to_cnt", 32'(n_to), 2);
        wait_newd(1'b1, "t4_next");
        chk("t4_dintx", 32'(dintx), 32'h5A);
        xm_mode = XM_AUTO;
        drain("t4_drain");
        cmp_launch("t4_order");

        // Write landing on the same edge as the pop
        xm_mode = XM_MANUAL;
        wr(8'h11, 1'b1); wr(8'h22, 1'b1); wr(8'h33, 1'b1);
        wait_newd(1'b1, "t5_launch");
        tx_in = 1'b0;
        wait_newd(1'b0, "t5_start");
        tx_in = 1'b1; donetx_in = 1'b1;
        cyc(); cyc();
        wr(8'h44, 1'b1);
        chk("t5_pop_sent", 32'(byte_sent), 1);
        chk("t5_count", 32'(count), 3);
        donetx_in = 1'b0;

        // 40 random bytes through a wrapping FIFO, random transmitter timing
        n_ovf = 0;
        xm_mode = XM_AUTO;
        base = frames_done; pend = 3; stall = 0;
        for (int i = 0; i < 40; i++) begin
            int g, guard;
            g = int'($urandom_range(0, 2));
            repeat (g) cyc();
            guard = 0;
            while ((pend - (frames_done - base)) >= DEPTH - 2 && guard < 2000) begin
                cyc(); guard++;
            end
            if (guard >= 2000) stall++;
            wr(8'($urandom), 1'b1);
            pend++;
        end
        chk("t5_pace", 32'(stall), 0);
        drain("t5_drain");
        chk("t5_ovf_cnt", 32'(n_ovf), 0);
        chk("t5_count_end", 32'(count), 0);
        cmp_launch("t5_order");

        // Reset in the middle of a frame
        xm_mode = XM_MANUAL;
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i), 1'b1);
        wait_newd(1'b1, "t6_launch");
        tx_in = 1'b0;
        wait_newd(1'b0, "t6_start");
        chk("t6_count_pre", 32'(count), 5);
        chk("t6_busy_pre", 32'(busy), 1);
        n_sent = 0; n_to = 0;
        rst = 1'b1;
        cyc();
        chk("t6_newd", 32'(newd), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_sent", 32'(byte_sent), 0);
        chk("t6_to", 32'(timeout_err), 0);
        rst = 1'b0; tx_in = 1'b1;
        repeat (10) cyc();
        chk("t6_sent_cnt", 32'(n_sent), 0);
        chk("t6_to_cnt", 32'(n_to), 0);
        chk("t6_idle", 32'(busy), 0);
        launch_q.delete();
        exp_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
